rf_wb_ctrl: RTL

Write-port arbiter and register scoreboard for the 32×32 register file. It shares the single RF write port between the pipeline WB stage and a long-latency unit (LLU, the multiply/divide unit). It tracks destination registers with an LLU result outstanding and raises the decode-stage hazard stall. It sits between WB/LLU and the RF write port, and feeds the hazard logic in ID.

---
 rtl/rf_wb_ctrl_if.sv | 46 ++++
 rtl/rf_wb_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/rf_wb_ctrl_if.sv
// rtl/rf_wb_ctrl_if.sv - bus bundle between WB/LLU/ID/RF and the write-port controller
//
// Purpose: groups every handshake and data signal of rf_wb_ctrl so the
// controller takes a single bus port. clk/rst stay outside the bundle.
// Ports (as seen from the controller, modport slave):
//   in : wb_we, wb_rd, wb_data, llu_valid, llu_rd, llu_data,
//        iss_valid, iss_rd, id_rs1, id_rs2, id_rd
//   out: wb_stall, llu_ready, iss_ready, id_stall, rf_we, rf_wa, rf_wd, pending
// The master modport is the mirror image (pipeline/LLU/RF side).
interface rf_wb_ctrl_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;

  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;

  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_stall;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending;

  modport slave (
    input  wb_we, wb_rd, wb_data, llu_valid, llu_rd, llu_data,
           iss_valid, iss_rd, id_rs1, id_rs2, id_rd,
    output wb_stall, llu_ready, iss_ready, id_stall, rf_we, rf_wa, rf_wd, pending
  );

  modport master (
    output wb_we, wb_rd, wb_data, llu_valid, llu_rd, llu_data,
           iss_valid, iss_rd, id_rs1, id_rs2, id_rd,
    input  wb_stall, llu_ready, iss_ready, id_stall, rf_we, rf_wa, rf_wd, pending
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - RF write-port arbiter (WB vs LLU) and LLU destination scoreboard
//
// Purpose: shares the single register-file write port between the WB stage
// and the long-latency unit. WB has priority; an LLU result that has lost
// STARVE_LIMIT consecutive cycles is forced through. Tracks registers with an
// outstanding LLU result and raises the ID hazard stall.
// Ports:
//   clk  - clock, state updates on posedge
//   rst  - asynchronous active-high reset
//   bus  - rf_wb_ctrl_if.slave (WB, LLU, issue, ID and RF write-port signals)
module rf_wb_ctrl #(
  parameter int STARVE_LIMIT = 3
) (
  input logic         clk,
  input logic         rst,
  rf_wb_ctrl_if.slave bus
);

  // Bit 0 is kept at zero so x0 can be indexed directly without a special case.
  logic [31:0] pendQ;
  logic [31:0] pendNext;
  logic [3:0]  waitCnt;
  logic [3:0]  waitNext;

  logic forceLlu;
  logic lluGrant;
  logic wbGrant;
  logic issFire;

  assign forceLlu = (waitCnt >= 4'(STARVE_LIMIT));
  assign lluGrant = bus.llu_valid & (~bus.wb_we | forceLlu);
  assign wbGrant  = bus.wb_we & ~lluGrant;
  assign issFire  = bus.iss_valid & bus.iss_ready & (bus.iss_rd != 5'd0);

  // Write-port mux and handshakes
  always_comb begin
    bus.rf_we     = 1'b0;
    bus.rf_wa     = 5'd0;
    bus.rf_wd     = 32'd0;
    bus.llu_ready = 1'b0;
    bus.wb_stall  = 1'b0;
    if (lluGrant) begin
      bus.rf_wa     = bus.llu_rd;
      bus.rf_wd     = bus.llu_data;
      bus.rf_we     = (bus.llu_rd != 5'd0);
      bus.llu_ready = 1'b1;
      bus.wb_stall  = bus.wb_we;
    end else if (wbGrant) begin
      bus.rf_wa = bus.wb_rd;
      bus.rf_wd = bus.wb_data;
      bus.rf_we = (bus.wb_rd != 5'd0);
    end
  end

  assign bus.pending   = pendQ;
  assign bus.iss_ready = ~pendQ[bus.iss_rd];
  assign bus.id_stall  = pendQ[bus.id_rs1] | pendQ[bus.id_rs2] | pendQ[bus.id_rd];

  // Clear first, then set, so an issue to the same rd in the same cycle wins.
  always_comb begin
    pendNext = pendQ;
    if (lluGrant) begin
      pendNext[bus.llu_rd] = 1'b0;
    end
    if (issFire) begin
      pendNext[bus.iss_rd] = 1'b1;
    end
    pendNext[0] = 1'b0;
  end

  always_comb begin
    waitNext = 4'd0;
    if (bus.llu_valid & ~lluGrant) begin
      waitNext = (waitCnt == 4'd15) ? 4'd15 : waitCnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendQ   <= 32'd0;
      waitCnt <= 4'd0;
    end else begin
      pendQ   <= pendNext;
      waitCnt <= waitNext;
    end
  end

endmodule
